cmos_stream_gen: RTL and testbench
==================================

# cmos_stream_gen

Parametrised camera-timing and pixel-address generator that replaces the fixed 800-wide camera model used to drive image-processing blocks in simulation. It produces `cmos_vsync`/`cmos_href` framing with programmable geometry and blanking, plus a byte index into a BMP image buffer with header offset, 4-byte row padding and optional vertical flip. It supports single-shot and N-frame bursts, so multi-frame filters can be exercised. It sits between the BMP byte array and the DUT's `in_vs`/`in_de`/`in_data` ports.

## Interface
- `H_ACTIVE`, 800: active pixels per line.
- `H_BLANK`, 160: blank cycles per line after the active pixels; must be ≥1.
- `V_ACTIVE`, 480: active lines per frame.
- `V_SYNC`, 2: lines with vsync high; must be ≥1.
- `V_BACK`, 4: blank lines after sync.
- `V_FRONT`, 2: blank lines after the active region; must be ≥1.
- `BPP`, 3: bytes per pixel in the buffer.
- `HDR_BYTES`, 54: byte offset of the pixel data.
- `FLIP`, 1: 1 = buffer is bottom-up and output is top-down; 0 = no flip.
- `IDX_W`, 32: width of the index.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  start request, sampled in IDLE.
- `frames`  in  8  frames per burst, sampled at start; 0 = continuous.
- `cmos_vsync`  out  1  frame sync, high during VSYNC lines.
- `cmos_href`  out  1  high for each valid pixel.
- `cmos_index`  out  IDX_W  byte address of the pixel's first byte; valid when `cmos_href` is high.
- `pix_x`  out  16  column of the current pixel.
- `pix_y`  out  16  output line of the current pixel (0 = first line sent).
- `frame_cnt`  out  16  frames completed since reset; wraps at 2^16.
- `frame_done`  out  1  one-cycle pulse on the last cycle of each frame.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Derived constants:
  - `STRIDE = ((H_ACTIVE*BPP+3)/4)*4`.
  - `LINE_LEN = H_ACTIVE + H_BLANK`.
- States and transitions: IDLE → VSYNC (V_SYNC lines) → VBACK (V_BACK lines; skipped if 0) → ACTIVE (V_ACTIVE lines) → VFRONT (V_FRONT lines) → next frame's VSYNC or IDLE.
- Each line is LINE_LEN cycles. An `h` counter runs 0..LINE_LEN-1 and a line counter counts lines within the current state.
- In ACTIVE, `cmos_href` is high while `h < H_ACTIVE`. `cmos_vsync` is high only in VSYNC.
- Indexing:
  - Row base at output line y: `HDR_BYTES + r*STRIDE`, where r = V_ACTIVE-1-y if FLIP, else r = y.
  - `cmos_index = rowbase + pix_x*BPP`.
  - Computed incrementally: add BPP per pixel, and step rowbase by ±STRIDE at line end. No multipliers in the datapath; multiplication by parameters only in constants.
- Burst control:
  - On leaving IDLE, latch `frames` into a remaining-frames counter.
  - At the end of VFRONT, decrement it (when non-zero). Return to IDLE when it reaches 0; continue when `frames` was 0.
- `enable` deasserted mid-frame: the current frame completes, then the block goes to IDLE. No frame is ever truncated.
- `enable` is ignored outside IDLE, except for this end-of-frame check.

## Timing
- All outputs are registered. Reset values: every output 0 and state IDLE.
- Start: `enable` high in IDLE at edge k → `cmos_vsync`=1 and `busy`=1 from cycle k+1.
- `cmos_index`, `pix_x` and `pix_y` are valid in the same cycle as `cmos_href`. Zero extra latency from href.
- Frame length is `(V_SYNC+V_BACK+V_ACTIVE+V_FRONT)*LINE_LEN` cycles. Back-to-back frames have no gap.
- `frame_done` and the `frame_cnt` increment occur in the same cycle: the last VFRONT cycle. When that cycle exits to IDLE, `busy` drops the following cycle.
- `rst` asserted mid-frame: the next cycle shows reset values, and all counters clear. It does not wait for the frame to finish.
- `frame_cnt` wraps from 0xFFFF to 0 with no flag.

## Structure
- Shared package `cmos_gen_pkg`: state enum (IDLE, VSYNC, VBACK, ACTIVE, VFRONT) and a `stride_f(h_active, bpp)` constant function.
- One sub-module, `line_timer`: the `h` counter with line-end strobe and href window. The vertical FSM and address logic stay in the top.

## Test plan
Small configuration: H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_SYNC=1, V_BACK=1, V_FRONT=1, BPP=3, HDR_BYTES=54 (STRIDE=12, 36 cycles/frame).
- FLIP=1, frames=1, enable pulse:
  - vsync high for 6 cycles.
  - First active line indices are 78, 81, 84, 87; then 66..75; then 54..63.
  - `frame_done` pulses once; `frame_cnt`=1; returns to IDLE.
- FLIP=0, same setup → first line indices are 54, 57, 60, 63 and the last line starts at 78.
- H_ACTIVE=5, BPP=3 → STRIDE=16 (padded). Second-line base is 70 with FLIP=0.
- frames=3 → exactly 3 contiguous frames (108 cycles, no gap); `frame_cnt`=3; `busy` low afterwards.
- frames=0 with `enable` dropped during ACTIVE of frame 2 → frame 2 completes in full, then IDLE.
- `rst` at cycle 20 of a frame → all outputs 0 the next cycle. A restart reproduces the first-frame sequence exactly.

Source files
------------

// File: rtl/cmos_gen_pkg.sv
// Shared types and constant helpers for the camera stream generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   state_e  : vertical frame state
//   stride_f : BMP row length in bytes, rounded up to a 4-byte boundary
package cmos_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    VFRONT
  } state_e;

  function automatic int unsigned stride_f(input int unsigned h_active,
                                           input int unsigned bpp);
    return ((h_active * bpp + 3) / 4) * 4;
  endfunction

endpackage

// File: rtl/cmos_stream_gen_if.sv
// Control and pixel-timing bundle between the stream generator and its sink.
// Latency: n/a (wires only).
// Backpressure: none; the generator free-runs once started.
//   enable/frames          : start request and burst length (sink -> generator)
//   cmos_vsync/cmos_href   : frame and pixel framing
//   cmos_index/pix_x/pix_y : buffer byte address and pixel coordinates
//   frame_cnt/frame_done   : completed-frame counter and end-of-frame pulse
//   busy                   : generator is not idle
interface cmos_stream_gen_if #(
  parameter int IDX_W = 32
);
  logic             enable;
  logic [7:0]       frames;
  logic             cmos_vsync;
  logic             cmos_href;
  logic [IDX_W-1:0] cmos_index;
  logic [15:0]      pix_x;
  logic [15:0]      pix_y;
  logic [15:0]      frame_cnt;
  logic             frame_done;
  logic             busy;

  modport master (
    input  enable, frames,
    output cmos_vsync, cmos_href, cmos_index, pix_x, pix_y,
           frame_cnt, frame_done, busy
  );

  modport slave (
    output enable, frames,
    input  cmos_vsync, cmos_href, cmos_index, pix_x, pix_y,
           frame_cnt, frame_done, busy
  );
endinterface

// File: rtl/line_timer.sv
// Horizontal line timer: h counter 0..LINE_LEN-1 with line-end strobe.
// Latency: flags describe the current h (line_end_o) or the next h (*_nxt_o).
// Backpressure: none; counts every cycle while run_i is high, held at 0 otherwise.
//   clk, rst     : clock, synchronous active-high reset
//   run_i        : generator is in a non-idle state
//   line_end_o   : current cycle is the last of the line
//   win_nxt_o    : next cycle falls in the active pixel window
//   first_nxt_o  : next cycle is h == 0
//   last_nxt_o   : next cycle is h == LINE_LEN-1
module line_timer #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_BLANK  = 160
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic line_end_o,
  output logic win_nxt_o,
  output logic first_nxt_o,
  output logic last_nxt_o
);

  localparam int unsigned LINE_LEN = H_ACTIVE + H_BLANK;
  localparam int          HW       = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;

  logic [HW-1:0] h_q, h_d;

  assign line_end_o = run_i && (h_q == HW'(LINE_LEN - 1));

  // Idle holds h at 0 so the first line after a start begins cleanly.
  always_comb begin
    h_d = '0;
    if (run_i && !line_end_o) h_d = h_q + HW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) h_q <= '0;
    else     h_q <= h_d;
  end

  assign win_nxt_o   = (h_d < HW'(H_ACTIVE));
  assign first_nxt_o = (h_d == '0);
  assign last_nxt_o  = (h_d == HW'(LINE_LEN - 1));

endmodule

// File: rtl/cmos_stream_gen.sv
// Camera timing (vsync/href) and BMP byte-address generator with bursts.
// Latency: enable sampled in IDLE at edge k -> vsync/busy from cycle k+1; index valid with href.
// Backpressure: none; a started frame always runs to completion.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cmos_stream_gen_if master (enable/frames in, timing and address out)
module cmos_stream_gen
  import cmos_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned H_BLANK   = 160,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 4,
  parameter int unsigned V_FRONT   = 2,
  parameter int unsigned BPP       = 3,
  parameter int unsigned HDR_BYTES = 54,
  parameter int unsigned FLIP      = 1,
  parameter int          IDX_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  cmos_stream_gen_if.master  bus
);

  localparam int unsigned      STRIDE = stride_f(H_ACTIVE, BPP);
  // Bottom-up buffers start output at the last stored row.
  localparam logic [IDX_W-1:0] ROW0   = (FLIP != 0) ?
                                        IDX_W'(HDR_BYTES + (V_ACTIVE - 1) * STRIDE) :
                                        IDX_W'(HDR_BYTES);
  localparam logic [IDX_W-1:0] STEP   = IDX_W'(STRIDE);
  localparam logic [IDX_W-1:0] PSTEP  = IDX_W'(BPP);

  state_e           state_q, state_d;
  logic [15:0]      line_q, line_d, line_lim;
  logic [7:0]       rem_q, rem_d;
  logic             cont_q, cont_d;
  logic [IDX_W-1:0] rowbase_q, rowbase_d;

  logic             vsync_q, vsync_d;
  logic             href_q, href_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [15:0]      pix_x_q, pix_x_d;
  logic [15:0]      pix_y_q, pix_y_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;

  logic line_end, win_nxt, first_nxt, last_nxt, line_last, last_frame;

  line_timer #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK)
  ) u_line_timer (
    .clk         (clk),
    .rst         (rst),
    .run_i       (state_q != IDLE),
    .line_end_o  (line_end),
    .win_nxt_o   (win_nxt),
    .first_nxt_o (first_nxt),
    .last_nxt_o  (last_nxt)
  );

  always_comb begin
    line_lim = '0;
    case (state_q)
      VSYNC:   line_lim = 16'(V_SYNC - 1);
      VBACK:   line_lim = 16'(V_BACK - 1);
      ACTIVE:  line_lim = 16'(V_ACTIVE - 1);
      VFRONT:  line_lim = 16'(V_FRONT - 1);
      default: line_lim = '0;
    endcase
  end

  assign line_last  = line_end && (line_q == line_lim);
  // frames == 0 latched as continuous; otherwise the frame with one left is the last.
  assign last_frame = !cont_q && (rem_q <= 8'd1);

  // Vertical FSM: state, line-in-state counter and burst bookkeeping.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    rem_d   = rem_q;
    cont_d  = cont_q;

    if (line_end) line_d = line_last ? 16'd0 : line_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = VSYNC;
          line_d  = '0;
          rem_d   = bus.frames;
          cont_d  = (bus.frames == 8'd0);
        end
      end
      VSYNC:  if (line_last) state_d = (V_BACK == 0) ? ACTIVE : VBACK;
      VBACK:  if (line_last) state_d = ACTIVE;
      ACTIVE: if (line_last) state_d = VFRONT;
      VFRONT: begin
        if (line_last) begin
          if (rem_q != 8'd0) rem_d = rem_q - 8'd1;
          // Dropping enable only takes effect here, so frames are never cut short.
          state_d = (last_frame || !bus.enable) ? IDLE : VSYNC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address path: row base reloads on entering ACTIVE and steps one stride per line.
  always_comb begin
    rowbase_d = rowbase_q;
    if (state_d == ACTIVE && state_q != ACTIVE)
      rowbase_d = ROW0;
    else if (state_q == ACTIVE && line_end)
      rowbase_d = (FLIP != 0) ? rowbase_q - STEP : rowbase_q + STEP;
  end

  // Outputs are registered from next-state values so they line up with state.
  always_comb begin
    vsync_d      = (state_d == VSYNC);
    busy_d       = (state_d != IDLE);
    href_d       = (state_d == ACTIVE) && win_nxt;
    frame_done_d = (state_d == VFRONT) && last_nxt && (line_d == 16'(V_FRONT - 1));
    frame_cnt_d  = frame_done_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
    index_d      = index_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    if (href_d) begin
      if (first_nxt) begin
        index_d = rowbase_d;
        pix_x_d = '0;
        pix_y_d = line_d;
      end else begin
        index_d = index_q + PSTEP;
        pix_x_d = pix_x_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      line_q       <= '0;
      rem_q        <= '0;
      cont_q       <= 1'b0;
      rowbase_q    <= '0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      index_q      <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      rem_q        <= rem_d;
      cont_q       <= cont_d;
      rowbase_q    <= rowbase_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      index_q      <= index_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.cmos_vsync = vsync_q;
  assign bus.cmos_href  = href_q;
  assign bus.cmos_index = index_q;
  assign bus.pix_x      = pix_x_q;
  assign bus.pix_y      = pix_y_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_cmos_stream_gen.sv
// Bench for cmos_stream_gen: small geometries, flip/no-flip, padding, bursts, reset.
// Three instances: A (FLIP=1), B (FLIP=0), C (H_ACTIVE=5 padded stride, FLIP=0).
module tb_cmos_stream_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmos_stream_gen_if #(.IDX_W(32)) a_if ();
  cmos_stream_gen_if #(.IDX_W(32)) b_if ();
  cmos_stream_gen_if #(.IDX_W(32)) c_if ();

  cmos_stream_gen #(
    .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3), .V_SYNC(1), .V_BACK(1), .V_FRONT(1),
    .BPP(3), .HDR_BYTES(54), .FLIP(1), .IDX_W(32)
  ) u_a (.clk(clk), .rst(rst), .bus(a_if.master));

  cmos_stream_gen #(
    .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3), .V_SYNC(1), .V_BACK(1), .V_FRONT(1),
    .BPP(3), .HDR_BYTES(54), .FLIP(0), .IDX_W(32)
  ) u_b (.clk(clk), .rst(rst), .bus(b_if.master));

  cmos_stream_gen #(
    .H_ACTIVE(5), .H_BLANK(2), .V_ACTIVE(3), .V_SYNC(1), .V_BACK(1), .V_FRONT(1),
    .BPP(3), .HDR_BYTES(54), .FLIP(0), .IDX_W(32)
  ) u_c (.clk(clk), .rst(rst), .bus(c_if.master));

  int checks = 0;
  int errors = 0;
  int busy_cyc, gaps, vs_cyc, done_n;
  int a_first [4] = '{78, 81, 84, 87};
  int b_first [4] = '{54, 57, 60, 63};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Small geometry: 6-cycle lines; line 0 VSYNC, 1 VBACK, 2..4 ACTIVE, 5 VFRONT.
  function automatic logic [31:0] exp_idx(input int flip, input int y, input int x);
    int r;
    r = (flip != 0) ? (2 - y) : y;
    return 32'(54 + r * 12 + x * 3);
  endfunction

  task automatic check_small(input string p, input int i, input int flip,
                             input logic vs, input logic hr, input logic [31:0] idx,
                             input logic [15:0] px, input logic [15:0] py,
                             input logic fd, input logic bz);
    int l, h;
    logic e_hr;
    l = i / 6;
    h = i % 6;
    e_hr = (l >= 2) && (l <= 4) && (h < 4);
    chk($sformatf("%s vsync c%0d", p, i), vs, (l == 0));
    chk($sformatf("%s href c%0d", p, i), hr, e_hr);
    if (e_hr) begin
      chk($sformatf("%s index c%0d", p, i), idx, exp_idx(flip, l - 2, h));
      chk($sformatf("%s pix_x c%0d", p, i), px, h);
      chk($sformatf("%s pix_y c%0d", p, i), py, l - 2);
    end
    chk($sformatf("%s frame_done c%0d", p, i), fd, (i == 35));
    chk($sformatf("%s busy c%0d", p, i), bz, 1);
  endtask

  task automatic check_zero(input string p);
    chk({p, " vsync"}, a_if.cmos_vsync, 0);
    chk({p, " href"}, a_if.cmos_href, 0);
    chk({p, " index"}, a_if.cmos_index, 0);
    chk({p, " pix_x"}, a_if.pix_x, 0);
    chk({p, " pix_y"}, a_if.pix_y, 0);
    chk({p, " frame_cnt"}, a_if.frame_cnt, 0);
    chk({p, " frame_done"}, a_if.frame_done, 0);
    chk({p, " busy"}, a_if.busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_if.enable = 1'b0; a_if.frames = 8'd0;
    b_if.enable = 1'b0; b_if.frames = 8'd0;
    c_if.enable = 1'b0; c_if.frames = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Single frame on all three instances.
    @(negedge clk);
    a_if.enable = 1'b1; a_if.frames = 8'd1;
    b_if.enable = 1'b1; b_if.frames = 8'd1;
    c_if.enable = 1'b1; c_if.frames = 8'd1;
    @(posedge clk);
    #1;
    a_if.enable = 1'b0; b_if.enable = 1'b0; c_if.enable = 1'b0;
    vs_cyc = 0;
    done_n = 0;
    for (int i = 0; i < 43; i++) begin
      @(negedge clk);
      if (i < 36) begin
        check_small("A", i, 1, a_if.cmos_vsync, a_if.cmos_href, a_if.cmos_index,
                    a_if.pix_x, a_if.pix_y, a_if.frame_done, a_if.busy);
        check_small("B", i, 0, b_if.cmos_vsync, b_if.cmos_href, b_if.cmos_index,
                    b_if.pix_x, b_if.pix_y, b_if.frame_done, b_if.busy);
      end
      vs_cyc += int'(a_if.cmos_vsync);
      done_n += int'(a_if.frame_done);
      if (i >= 12 && i < 16) begin
        chk($sformatf("A first line c%0d", i), a_if.cmos_index, a_first[i-12]);
        chk($sformatf("B first line c%0d", i), b_if.cmos_index, b_first[i-12]);
      end
      if (i == 18) chk("A second line base", a_if.cmos_index, 66);
      if (i == 24) begin
        chk("A last line base", a_if.cmos_index, 54);
        chk("B last line base", b_if.cmos_index, 78);
      end
      if (i == 27) chk("A last pixel", a_if.cmos_index, 63);
      if (i == 36) begin
        chk("A idle after frame", a_if.busy, 0);
        chk("A frame_cnt", a_if.frame_cnt, 1);
        chk("B idle after frame", b_if.busy, 0);
      end
      if (i == 14) chk("C first line base", c_if.cmos_index, 54);
      if (i == 18) chk("C last pixel line0", c_if.cmos_index, 66);
      if (i == 21) begin
        chk("C second line base", c_if.cmos_index, 70);
        chk("C second line pix_y", c_if.pix_y, 1);
      end
      if (i == 22) chk("C second line px1", c_if.cmos_index, 73);
      if (i == 41) chk("C frame_done", c_if.frame_done, 1);
      if (i == 42) chk("C idle after frame", c_if.busy, 0);
    end
    chk("A vsync cycles", vs_cyc, 6);
    chk("A frame_done pulses", done_n, 1);

    // Burst of three frames with enable held: contiguous, then IDLE.
    do_reset();
    a_if.frames = 8'd3;
    a_if.enable = 1'b1;
    @(posedge clk);
    busy_cyc = 0; gaps = 0; vs_cyc = 0; done_n = 0;
    for (int t = 0; t < 400 && done_n < 3; t++) begin
      @(negedge clk);
      if (a_if.busy) busy_cyc++;
      else gaps++;
      vs_cyc += int'(a_if.cmos_vsync);
      done_n += int'(a_if.frame_done);
    end
    chk("burst frames done", done_n, 3);
    chk("burst busy cycles", busy_cyc, 108);
    chk("burst gaps", gaps, 0);
    chk("burst vsync cycles", vs_cyc, 18);
    chk("burst frame_cnt", a_if.frame_cnt, 3);
    @(posedge clk);
    #1 a_if.enable = 1'b0;
    @(negedge clk);
    chk("burst busy after", a_if.busy, 0);
    @(negedge clk);
    chk("burst stays idle", a_if.busy, 0);

    // Continuous mode, enable dropped in ACTIVE of frame 2.
    do_reset();
    a_if.frames = 8'd0;
    a_if.enable = 1'b1;
    @(posedge clk);
    busy_cyc = 0;
    for (int t = 0; t < 49; t++) begin
      @(negedge clk);
      busy_cyc += int'(a_if.busy);
      if (t == 48) chk("cont frame2 first pixel", a_if.cmos_index, 78);
    end
    a_if.enable = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!a_if.busy) break;
      busy_cyc++;
    end
    chk("cont busy cycles", busy_cyc, 72);
    chk("cont frame_cnt", a_if.frame_cnt, 2);
    chk("cont idle", a_if.busy, 0);
    repeat (3) @(negedge clk);
    chk("cont stays idle", a_if.busy, 0);

    // Reset in the middle of a frame, then a clean restart.
    do_reset();
    a_if.frames = 8'd1;
    a_if.enable = 1'b1;
    @(posedge clk);
    #1 a_if.enable = 1'b0;
    for (int i = 0; i < 21; i++) @(negedge clk);
    chk("pre-reset href c20", a_if.cmos_href, 1);
    chk("pre-reset index c20", a_if.cmos_index, 72);
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid reset");
    rst = 1'b0;
    @(negedge clk);
    a_if.enable = 1'b1;
    @(posedge clk);
    #1 a_if.enable = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      if (i < 36)
        check_small("R", i, 1, a_if.cmos_vsync, a_if.cmos_href, a_if.cmos_index,
                    a_if.pix_x, a_if.pix_y, a_if.frame_done, a_if.busy);
      else begin
        chk("R idle", a_if.busy, 0);
        chk("R frame_cnt", a_if.frame_cnt, 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
